// File: rtl/pipe_stage_skid.sv
// Registered-ready pipeline stage: a main register drives the outputs and a one-entry
// skid register absorbs the entry accepted while the main register is stalled.
module pipe_stage_skid #(
    parameter int CTRL_W              = 9,
    parameter int DATA_W              = 138,
    parameter int ZERO_CTRL_ON_BUBBLE = 1,
    parameter int CNT_W               = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_flush,
    input  logic              i_cnt_clr,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic              s_valid;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;
    logic [CNT_W-1:0]  stall_cnt;

    logic accept;
    logic m_free;
    logic stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Ready depends only on skid occupancy, so it never combinationally follows i_ready.
    assign o_ready = !s_valid;
    assign accept  = i_valid & o_ready;
    assign m_free  = !m_valid | i_ready;
    assign stall   = m_valid & !i_ready;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
            m_data  <= '0;
            s_valid <= 1'b0;
            s_ctrl  <= '0;
            s_data  <= '0;
        end else if (i_flush) begin
            // Payload registers keep their contents; only validity and control are wiped.
            m_valid <= 1'b0;
            m_ctrl  <= '0;
            s_valid <= 1'b0;
            s_ctrl  <= '0;
        end else if (m_free) begin
            if (s_valid) begin
                m_valid <= 1'b1;
                m_ctrl  <= s_ctrl;
                m_data  <= s_data;
                s_valid <= 1'b0;
            end else if (accept) begin
                m_valid <= 1'b1;
                m_ctrl  <= i_ctrl;
                m_data  <= i_data;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (accept) begin
            s_valid <= 1'b1;
            s_ctrl  <= i_ctrl;
            s_data  <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            stall_cnt <= '0;
        else if (i_cnt_clr)
            stall_cnt <= '0;
        else if (stall)
            stall_cnt <= sat_inc(stall_cnt);
    end

    assign o_valid     = m_valid;
    assign o_data      = m_data;
    assign o_ctrl      = ((ZERO_CTRL_ON_BUBBLE != 0) && !m_valid) ? '0 : m_ctrl;
    assign o_stall_cnt = stall_cnt;

endmodule
